// File: rtl/sample_stream_rx.sv
// Receiver for the adc_sampler interface: edge-detects sample_clk, buffers samples in a
// first-word fall-through FIFO with per-entry epoch marker. Optional: SAMPLE_RX_OVF_CNT_EN.
module sample_stream_rx #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned WINDOW_LEN = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        sample_in,
  input  logic                     sample_clk,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     ovf_clr
`ifdef SAMPLE_RX_OVF_CNT_EN
  ,
  output logic [15:0]              ovf_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned WW = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam logic [WW-1:0] WIN_MAX  = WW'(WINDOW_LEN - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

  logic              sclk_d_q;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic [WW-1:0]     win_q, win_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W:0]   mem [DEPTH];

  logic strobe, rd_en, wr_en, drop, full, wr_last;
  logic [DATA_W:0] head;

  always_comb begin
    strobe  = sample_clk & ~sclk_d_q;
    m_valid = (level_q != '0);
    full    = (level_q == FULL_LVL);
    rd_en   = m_valid & m_ready;
    // A read in a full cycle frees the slot the concurrent write lands in.
    wr_en   = strobe & (~full | rd_en);
    drop    = strobe & full & ~rd_en;
    wr_last = (win_q == WIN_MAX);

    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;

    level_d = level_q;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase

    win_d = win_q;
    if (wr_en) win_d = wr_last ? '0 : win_q + WW'(1);

    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;

    head     = mem[rd_ptr_q];
    m_data   = m_valid ? head[DATA_W-1:0] : '0;
    m_last   = m_valid & head[DATA_W];
    level    = level_q;
    overflow = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Preloaded high so a sample_clk already high at reset release is not an edge.
      sclk_d_q <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      win_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sclk_d_q <= sample_clk;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      win_q    <= win_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_ptr_q] <= {wr_last, sample_in};
  end

`ifdef SAMPLE_RX_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                          ovf_cnt_q <= '0;
    else if (ovf_clr)                 ovf_cnt_q <= {15'd0, drop};
    else if (drop && ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + 16'd1;
  end

  always_comb ovf_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_sample_stream_rx.sv
// Directed bench for sample_stream_rx (DEPTH=16, WINDOW_LEN=4): vector table plus
// hand sequences for reset, overflow, full-plus-read and a randomised producer/consumer run.
module tb_sample_stream_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] sample_in = '0;
  logic        sample_clk = 1'b0;
  logic [31:0] m_data;
  logic        m_last, m_valid;
  logic        m_ready = 1'b0;
  logic [4:0]  level;
  logic        overflow;
  logic        ovf_clr = 1'b0;
`ifdef SAMPLE_RX_OVF_CNT_EN
  logic [15:0] ovf_count;
`endif

  int checks = 0;
  int failures = 0;

  sample_stream_rx #(.DATA_W(32), .DEPTH(16), .WINDOW_LEN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_in  (sample_in),
    .sample_clk (sample_clk),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .level      (level),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
`ifdef SAMPLE_RX_OVF_CNT_EN
    ,
    .ovf_count  (ovf_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, sc;
    logic [31:0] din;
    logic        rdy, clr;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic [4:0]  elev;
    logic        eovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int r, int sc, int din, int rdy, int clr,
                              int ev, int ed, int el, int elev, int eovf);
    vec_t v;
    v.rst = r[0];  v.sc = sc[0];  v.din = 32'(din);  v.rdy = rdy[0];  v.clr = clr[0];
    v.ev = ev[0];  v.ed = 32'(ed);  v.el = el[0];  v.elev = 5'(elev);  v.eovf = eovf[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic sc);
    rst = 1'b1; sample_clk = sc; m_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  // Fill with k=1..n, one strobe every two cycles, m_ready low.
  task automatic fill(input int n);
    m_ready = 1'b0;
    sample_clk = 1'b0; step();
    for (int k = 1; k <= n; k++) begin
      sample_clk = 1'b1; sample_in = 32'(k); step();
      sample_clk = 1'b0; sample_in = '0;     step();
    end
  endtask

  task automatic drain(input string nm, input int first, input int last_k);
    sample_clk = 1'b0; m_ready = 1'b1;
    for (int k = first; k <= last_k; k++) begin
      chk({nm, "_valid"}, 32'(m_valid), 32'd1);
      chk({nm, "_data"},  m_data,       32'(k));
      chk({nm, "_last"},  32'(m_last),  32'((k % 4) == 0));
      step();
    end
    m_ready = 1'b0;
    chk({nm, "_empty_level"}, 32'(level), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int q[$];
    int exp_v;
    int guard;

    // T1: reset with sample_clk high must not produce a write on release
    do_reset(1'b1);
    chk("t1_valid_rst", 32'(m_valid), 32'd0);
    chk("t1_data_rst",  m_data,       32'd0);
    chk("t1_last_rst",  32'(m_last),  32'd0);
    repeat (3) begin
      step();
      chk("t1_valid", 32'(m_valid), 32'd0);
      chk("t1_level", 32'(level),   32'd0);
      chk("t1_ovf",   32'(overflow), 32'd0);
    end

    // T2 (latency, pulse width, hold) and T3 (window marker) as vectors
    tbl.push_back(mk(1, 0, 0,           0, 0, 0, 0,           0, 0, 0));
    tbl.push_back(mk(0, 0, 0,           1, 0, 0, 0,           0, 0, 0));
    tbl.push_back(mk(0, 1, 'hDEADBEEF,  1, 0, 1, 'hDEADBEEF,  0, 1, 0));
    tbl.push_back(mk(0, 1, 5,           0, 0, 1, 'hDEADBEEF,  0, 1, 0));
    tbl.push_back(mk(0, 0, 0,           1, 0, 0, 0,           0, 0, 0));
    tbl.push_back(mk(1, 0, 0,           0, 0, 0, 0,           0, 0, 0));
    tbl.push_back(mk(0, 0, 0,           1, 0, 0, 0,           0, 0, 0));
    for (int k = 1; k <= 9; k++) begin
      tbl.push_back(mk(0, 1, k, 1, 0, 1, k, ((k == 4) || (k == 8)) ? 1 : 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    end
    foreach (tbl[i]) begin
      rst = tbl[i].rst; sample_clk = tbl[i].sc; sample_in = tbl[i].din;
      m_ready = tbl[i].rdy; ovf_clr = tbl[i].clr;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(m_valid),  32'(tbl[i].ev));
      chk($sformatf("vec%0d_level", i), 32'(level),    32'(tbl[i].elev));
      chk($sformatf("vec%0d_ovf", i),   32'(overflow), 32'(tbl[i].eovf));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_data", i), m_data,      tbl[i].ed);
        chk($sformatf("vec%0d_last", i), 32'(m_last), 32'(tbl[i].el));
      end
    end
    rst = 1'b0; m_ready = 1'b0; sample_clk = 1'b0;

    // T4: overflow with 18 strobes into 16 entries
    do_reset(1'b0);
    fill(18);
    chk("t4_level", 32'(level),    32'd16);
    chk("t4_ovf",   32'(overflow), 32'd1);
`ifdef SAMPLE_RX_OVF_CNT_EN
    chk("t4_cnt",   32'(ovf_count), 32'd2);
`endif
    // drop and clear in the same cycle: set wins, count restarts at 1
    sample_clk = 1'b1; sample_in = 32'd99; ovf_clr = 1'b1; step();
    chk("t4_setwins_ovf", 32'(overflow), 32'd1);
    chk("t4_setwins_lvl", 32'(level),    32'd16);
`ifdef SAMPLE_RX_OVF_CNT_EN
    chk("t4_setwins_cnt", 32'(ovf_count), 32'd1);
`endif
    sample_clk = 1'b0; step();
    ovf_clr = 1'b0;
    chk("t4_clr_ovf", 32'(overflow), 32'd0);
`ifdef SAMPLE_RX_OVF_CNT_EN
    chk("t4_clr_cnt", 32'(ovf_count), 32'd0);
`endif
    drain("t4", 1, 16);

    // T5: full, strobe plus read in the same cycle
    do_reset(1'b0);
    fill(16);
    chk("t5_full", 32'(level), 32'd16);
    sample_clk = 1'b1; sample_in = 32'd17; m_ready = 1'b1; step();
    m_ready = 1'b0; sample_clk = 1'b0;
    chk("t5_level", 32'(level),    32'd16);
    chk("t5_ovf",   32'(overflow), 32'd0);
    drain("t5", 2, 17);

    // T6: random-period producer, random-ready consumer, scoreboard
    do_reset(1'b0);
    sample_clk = 1'b0; step();
    for (int n = 0; n < 200; n++) begin
      int p, h;
      p = int'($urandom_range(4, 7));
      h = int'($urandom_range(1, 2));
      for (int i = 0; i < p; i++) begin
        m_ready = 1'($urandom_range(0, 1));
        if (m_valid && m_ready) begin
          if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL t6_spurious: got %h expected no data", m_data);
          end else begin
            exp_v = q.pop_front();
            chk("t6_data", m_data, 32'(exp_v));
          end
        end
        sample_in = $urandom;
        sample_clk = (i < h);
        if (i == 0) q.push_back(int'(sample_in));
        step();
      end
    end
    sample_clk = 1'b0; m_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 64) begin
      if (m_valid) begin
        exp_v = q.pop_front();
        chk("t6_drain", m_data, 32'(exp_v));
      end
      step();
      guard++;
    end
    chk("t6_left",  32'(q.size()),  32'd0);
    chk("t6_level", 32'(level),     32'd0);
    chk("t6_ovf",   32'(overflow),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
